// File: rtl/lsu_dmem.sv
// lsu_dmem: load/store unit bridging the pipeline to a word-wide data memory.
// Define MISALIGN_SPLIT_EN to split lane-crossing accesses into two words; otherwise they are rejected.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef MEM_MODE_B
`define MEM_MODE_B  3'b000
`define MEM_MODE_H  3'b001
`define MEM_MODE_W  3'b010
`define MEM_MODE_BU 3'b100
`define MEM_MODE_HU 3'b101
`endif

module lsu_dmem #(
    parameter logic [`XLEN-1:0] ADDR_OFFSET = 32'h10000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [2:0]       req_mode,
    input  logic [`XLEN-1:0] req_addr,
    input  logic [`XLEN-1:0] req_wdata,
    output logic             req_ready,
    output logic             resp_valid,
    output logic [`XLEN-1:0] resp_data,
    output logic             resp_err,
    output logic [`XLEN-1:0] mem_addr,
    output logic [`XLEN-1:0] mem_wdata,
    output logic [3:0]       mem_wstrb,
    output logic             mem_we,
    output logic             mem_re,
    input  logic [`XLEN-1:0] mem_rdata,
    input  logic             mem_ready
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready high
    // ACC0  | first (or only) word access at the base word
    // ACC1  | second word access of a lane-crossing request
    // RESP  | one-cycle response pulse
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t state, state_nxt;

    logic             we_q;
    logic [2:0]       mode_q;
    logic [`XLEN-1:0] addr_q;
    logic [`XLEN-1:0] wdata_q;
    logic [`XLEN-1:0] rdata0_q;
    logic [`XLEN-1:0] data_q;
    logic             err_q;

    function automatic logic [2:0] mode_size(input logic [2:0] mode);
        case (mode)
            `MEM_MODE_B, `MEM_MODE_BU: mode_size = 3'd1;
            `MEM_MODE_H, `MEM_MODE_HU: mode_size = 3'd2;
            default:                   mode_size = 3'd4;
        endcase
    endfunction

    logic req_mode_ok;
    logic req_misaligned;
    logic req_illegal;

    always_comb begin
        case (req_mode)
            `MEM_MODE_B, `MEM_MODE_H, `MEM_MODE_W: req_mode_ok = 1'b1;
            `MEM_MODE_BU, `MEM_MODE_HU:            req_mode_ok = ~req_we;
            default:                               req_mode_ok = 1'b0;
        endcase
`ifdef MISALIGN_SPLIT_EN
        req_misaligned = 1'b0;
`else
        req_misaligned = ((mode_size(req_mode) == 3'd2) && req_addr[0]) ||
                         ((mode_size(req_mode) == 3'd4) && (req_addr[1:0] != 2'b00));
`endif
        req_illegal = ~req_mode_ok | req_misaligned;
    end

    logic [1:0]       off;
    logic [2:0]       acc_size;
    logic             crossing;
    logic [3:0]       lane_mask;
    logic [7:0]       strb_wide;
    logic [63:0]      wdata_wide;
    logic [63:0]      rdata_wide;
    logic [`XLEN-1:0] base_addr;
    logic [`XLEN-1:0] ld_raw;
    logic [`XLEN-1:0] ld_ext;

    assign off        = addr_q[1:0];
    assign acc_size   = mode_size(mode_q);
    assign crossing   = ({1'b0, off} + acc_size) > 3'd4;
    assign lane_mask  = (acc_size == 3'd1) ? 4'b0001 : (acc_size == 3'd2) ? 4'b0011 : 4'b1111;
    // Lanes and data are positioned across a 64-bit window: low half for ACC0, high half for ACC1.
    assign strb_wide  = {4'b0000, lane_mask} << off;
    assign wdata_wide = {32'b0, wdata_q} << {off, 3'b000};
    assign rdata_wide = (state == ACC1) ? {mem_rdata, rdata0_q} : {32'b0, mem_rdata};
    assign ld_raw     = 32'(rdata_wide >> {off, 3'b000});
    assign base_addr  = (addr_q - ADDR_OFFSET) & 32'hFFFF_FFFC;

    always_comb begin
        case (mode_q)
            `MEM_MODE_B:  ld_ext = {{24{ld_raw[7]}}, ld_raw[7:0]};
            `MEM_MODE_H:  ld_ext = {{16{ld_raw[15]}}, ld_raw[15:0]};
            `MEM_MODE_BU: ld_ext = {24'b0, ld_raw[7:0]};
            `MEM_MODE_HU: ld_ext = {16'b0, ld_raw[15:0]};
            default:      ld_ext = ld_raw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            mode_q   <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        mode_q  <= req_mode;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        err_q   <= req_illegal;
                        data_q  <= '0;
                    end
                end
                ACC0: begin
                    if (mem_ready) begin
                        rdata0_q <= mem_rdata;
                        if (!crossing && !we_q) data_q <= ld_ext;
                    end
                end
                ACC1: begin
                    if (mem_ready && !we_q) data_q <= ld_ext;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        resp_err   = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wstrb  = 4'b0000;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_illegal ? RESP : ACC0;
            end
            ACC0: begin
                mem_addr  = base_addr;
                mem_wdata = we_q ? wdata_wide[31:0] : '0;
                mem_wstrb = strb_wide[3:0];
                mem_we    = we_q;
                mem_re    = ~we_q;
                if (mem_ready) state_nxt = crossing ? ACC1 : RESP;
            end
            ACC1: begin
                mem_addr  = base_addr + 32'd4;
                mem_wdata = we_q ? wdata_wide[63:32] : '0;
                mem_wstrb = strb_wide[7:4];
                mem_we    = we_q;
                mem_re    = ~we_q;
                if (mem_ready) state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_data  = data_q;
                resp_err   = err_q;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_dmem.sv
// tb_lsu_dmem: directed vectors with a response scoreboard and a memory-access scoreboard.
`timescale 1ns/1ps
`ifndef XLEN
`define XLEN 32
`endif
`ifndef MEM_MODE_B
`define MEM_MODE_B  3'b000
`define MEM_MODE_H  3'b001
`define MEM_MODE_W  3'b010
`define MEM_MODE_BU 3'b100
`define MEM_MODE_HU 3'b101
`endif

module tb_lsu_dmem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [2:0]  req_mode;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_data;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        mem_we, mem_re, mem_ready;

    logic [31:0] mem_arr [4];
    assign mem_rdata = mem_arr[mem_addr[3:2]];

    always #5 clk = ~clk;

    lsu_dmem #(.ADDR_OFFSET(32'h10000)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_mode(req_mode),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } acc_t;

    resp_t sb_q[$];
    acc_t  acc_q[$];
    resp_t mon_r;
    acc_t  mon_a;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit started = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] byte_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    // Monitor: pops expected responses and expected memory accesses as the DUT presents them.
    always @(negedge clk) begin
        if (started && resp_valid) begin
            if (sb_q.size() == 0) begin
                chk("resp_unexpected", {31'b0, resp_valid}, 32'h0);
            end else begin
                mon_r = sb_q.pop_front();
                chk("resp_data", resp_data, mon_r.data);
                chk("resp_err", {31'b0, resp_err}, {31'b0, mon_r.err});
                chk("resp_cycle", 32'(cyc), 32'(mon_r.cyc));
            end
        end
        if (started && mem_ready && (mem_re || mem_we)) begin
            if (acc_q.size() == 0) begin
                chk("mem_unexpected", {30'b0, mem_re, mem_we}, 32'h0);
            end else begin
                mon_a = acc_q.pop_front();
                chk("mem_addr", mem_addr, mon_a.addr);
                chk("mem_we", {31'b0, mem_we}, {31'b0, mon_a.we});
                chk("mem_re", {31'b0, mem_re}, {31'b0, ~mon_a.we});
                chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, mon_a.strb});
                if (mon_a.we)
                    chk("mem_wdata", mem_wdata & byte_mask(mon_a.strb),
                        mon_a.wdata & byte_mask(mon_a.strb));
            end
        end
    end

    task automatic exp_acc(input logic [31:0] addr, input logic we, input logic [3:0] strb,
                           input logic [31:0] wdata);
        acc_q.push_back('{addr, we, strb, wdata});
    endtask

    // Entered and left just after a rising edge.
    task automatic issue(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_data,
                         input logic exp_err, input int lat, output int acc_cyc);
        req_valid = 1'b1;
        req_we    = we;
        req_mode  = mode;
        req_addr  = addr;
        req_wdata = wdata;
        acc_cyc   = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc_cyc = cyc;
                break;
            end
        end
        if (acc_cyc < 0) chk("accept_timeout", {31'b0, req_ready}, 32'h1);
        else sb_q.push_back('{exp_data, exp_err, acc_cyc + lat});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 20; n++) begin
            if (sb_q.size() == 0 && acc_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        if (sb_q.size() != 0 || acc_q.size() != 0) begin
            chk("drain_timeout", 32'(sb_q.size() + acc_q.size()), 32'h0);
            sb_q.delete();
            acc_q.delete();
        end
    endtask

    task automatic run(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_data,
                       input logic exp_err, input int lat);
        int t;
        issue(we, mode, addr, wdata, exp_data, exp_err, lat, t);
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_mode = 3'b000;
        req_addr = '0; req_wdata = '0; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) mem_arr[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        started = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_mem_re", {31'b0, mem_re}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Signed byte load at offset 1
        mem_arr[1] = 32'h0000_8000;
        exp_acc(32'h4, 1'b0, 4'b0010, 32'h0);
        run(1'b0, `MEM_MODE_B, 32'h10005, 32'h0, 32'hFFFF_FF80, 1'b0, 2);

        // Halfword store to upper lanes
        exp_acc(32'h0, 1'b1, 4'b1100, 32'hABCD_0000);
        run(1'b1, `MEM_MODE_H, 32'h10002, 32'h1234_ABCD, 32'h0, 1'b0, 2);

        // Word load at offset 3
        mem_arr[0] = 32'hDD00_0000;
        mem_arr[1] = 32'h00AA_BBCC;
`ifdef MISALIGN_SPLIT_EN
        exp_acc(32'h0, 1'b0, 4'b1000, 32'h0);
        exp_acc(32'h4, 1'b0, 4'b0111, 32'h0);
        run(1'b0, `MEM_MODE_W, 32'h10003, 32'h0, 32'hAABB_CCDD, 1'b0, 3);
`else
        run(1'b0, `MEM_MODE_W, 32'h10003, 32'h0, 32'h0, 1'b1, 1);
`endif

        // Aligned loads with every extension mode
        mem_arr[2] = 32'hCAFE_BABE;
        exp_acc(32'h8, 1'b0, 4'b1111, 32'h0);
        run(1'b0, `MEM_MODE_W, 32'h10008, 32'h0, 32'hCAFE_BABE, 1'b0, 2);
        exp_acc(32'h8, 1'b0, 4'b1100, 32'h0);
        run(1'b0, `MEM_MODE_H, 32'h1000A, 32'h0, 32'hFFFF_CAFE, 1'b0, 2);
        exp_acc(32'h8, 1'b0, 4'b1100, 32'h0);
        run(1'b0, `MEM_MODE_HU, 32'h1000A, 32'h0, 32'h0000_CAFE, 1'b0, 2);
        exp_acc(32'h8, 1'b0, 4'b0011, 32'h0);
        run(1'b0, `MEM_MODE_H, 32'h10008, 32'h0, 32'hFFFF_BABE, 1'b0, 2);
        exp_acc(32'h8, 1'b0, 4'b1000, 32'h0);
        run(1'b0, `MEM_MODE_BU, 32'h1000B, 32'h0, 32'h0000_00CA, 1'b0, 2);
        exp_acc(32'h8, 1'b0, 4'b1000, 32'h0);
        run(1'b0, `MEM_MODE_B, 32'h1000B, 32'h0, 32'hFFFF_FFCA, 1'b0, 2);

        // Byte and word stores
        exp_acc(32'h4, 1'b1, 4'b1000, 32'h5500_0000);
        run(1'b1, `MEM_MODE_B, 32'h10007, 32'hFFFF_FF55, 32'h0, 1'b0, 2);
        exp_acc(32'hC, 1'b1, 4'b1111, 32'hDEAD_BEEF);
        run(1'b1, `MEM_MODE_W, 32'h1000C, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);

        // Illegal modes: no access, immediate error response
        run(1'b1, `MEM_MODE_BU, 32'h10000, 32'h1, 32'h0, 1'b1, 1);
        run(1'b1, `MEM_MODE_HU, 32'h10000, 32'h1, 32'h0, 1'b1, 1);
        run(1'b0, 3'b011, 32'h10000, 32'h0, 32'h0, 1'b1, 1);
        run(1'b1, 3'b111, 32'h10004, 32'h0, 32'h0, 1'b1, 1);

        // Misaligned but non-crossing, and crossing accesses
        mem_arr[0] = 32'h33C4_5566;
`ifdef MISALIGN_SPLIT_EN
        exp_acc(32'h0, 1'b0, 4'b0110, 32'h0);
        run(1'b0, `MEM_MODE_H, 32'h10001, 32'h0, 32'hFFFF_C455, 1'b0, 2);
        exp_acc(32'h0, 1'b1, 4'b1100, 32'h3344_0000);
        exp_acc(32'h4, 1'b1, 4'b0011, 32'h0000_1122);
        run(1'b1, `MEM_MODE_W, 32'h10002, 32'h1122_3344, 32'h0, 1'b0, 3);
        exp_acc(32'h0, 1'b0, 4'b1000, 32'h0);
        exp_acc(32'h4, 1'b0, 4'b0001, 32'h0);
        run(1'b0, `MEM_MODE_HU, 32'h10003, 32'h0, 32'h0000_CC33, 1'b0, 3);
`else
        run(1'b0, `MEM_MODE_H, 32'h10001, 32'h0, 32'h0, 1'b1, 1);
        run(1'b1, `MEM_MODE_W, 32'h10002, 32'h1122_3344, 32'h0, 1'b1, 1);
        run(1'b0, `MEM_MODE_HU, 32'h10003, 32'h0, 32'h0, 1'b1, 1);
`endif

        // Address arithmetic wraps modulo 2^32
        mem_arr[3] = 32'h8000_0000;
        exp_acc(32'hFFFF_FFFC, 1'b0, 4'b1000, 32'h0);
        run(1'b0, `MEM_MODE_B, 32'h0000_FFFF, 32'h0, 32'hFFFF_FF80, 1'b0, 2);
`ifdef MISALIGN_SPLIT_EN
        exp_acc(32'hFFFF_FFFC, 1'b0, 4'b1100, 32'h0);
        exp_acc(32'h0000_0000, 1'b0, 4'b0011, 32'h0);
        run(1'b0, `MEM_MODE_W, 32'h0000_FFFE, 32'h0, 32'h5566_8000, 1'b0, 3);
`else
        run(1'b0, `MEM_MODE_W, 32'h0000_FFFE, 32'h0, 32'h0, 1'b1, 1);
`endif

        // Memory stall of five cycles in ACC0
        mem_ready = 1'b0;
        exp_acc(32'h8, 1'b0, 4'b1111, 32'h0);
        issue(1'b0, `MEM_MODE_W, 32'h10008, 32'h0, 32'hCAFE_BABE, 1'b0, 7, t1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_mem_addr", mem_addr, 32'h8);
            chk("stall_mem_re", {31'b0, mem_re}, 32'h1);
            chk("stall_mem_wstrb", {28'b0, mem_wstrb}, 32'hF);
            chk("stall_req_ready", {31'b0, req_ready}, 32'h0);
            chk("stall_resp_valid", {31'b0, resp_valid}, 32'h0);
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        drain();

        // Back-to-back requests
        exp_acc(32'h8, 1'b0, 4'b1111, 32'h0);
        exp_acc(32'h4, 1'b0, 4'b0001, 32'h0);
        issue(1'b0, `MEM_MODE_W, 32'h10008, 32'h0, 32'hCAFE_BABE, 1'b0, 2, t1);
        issue(1'b0, `MEM_MODE_B, 32'h10004, 32'h0, 32'hFFFF_FFCC, 1'b0, 2, t2);
        chk("b2b_accept_cycle", 32'(t2), 32'(t1 + 3));
        drain();

        // Reset during an in-flight access abandons it without a response
        req_valid = 1'b1; req_we = 1'b0; req_mode = `MEM_MODE_W; req_wdata = '0;
`ifdef MISALIGN_SPLIT_EN
        req_addr = 32'h10003;
        exp_acc(32'h0, 1'b0, 4'b1000, 32'h0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("inflight_mem_re", {31'b0, mem_re}, 32'h1);
        chk("inflight_mem_addr", mem_addr, 32'h4);
`else
        req_addr = 32'h10000;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("inflight_mem_re", {31'b0, mem_re}, 32'h1);
        chk("inflight_mem_addr", mem_addr, 32'h0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_mem_re", {31'b0, mem_re}, 32'h0);
        chk("post_rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("post_rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        @(posedge clk);
        #1;
        drain();
        mem_arr[0] = 32'h0000_8001;
        exp_acc(32'h0, 1'b0, 4'b0011, 32'h0);
        run(1'b0, `MEM_MODE_HU, 32'h10000, 32'h0, 32'h0000_8001, 1'b0, 2);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
